// File: rtl/rv32_multicycle_ctrl_if.sv
// Control bundle between the RV32I multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface rv32_multicycle_ctrl_if;
    logic       zero;
    logic       lt;
    logic [6:0] OPC;
    logic [2:0] Func3;
    logic [6:0] Func7;

    logic [3:0] ALU_OP;
    logic       SrcA_SEL;
    logic       SrcB_SEL;
    logic       fetch;
    logic [1:0] Sel_Reg_In;
    logic [1:0] PC_Control;
    logic [2:0] imm_SEL;
    logic       RD_WE;
    logic       WE;
    logic       imm_extend_WE;

    modport master (
        input  zero, lt, OPC, Func3, Func7,
        output ALU_OP, SrcA_SEL, SrcB_SEL, fetch, Sel_Reg_In, PC_Control,
               imm_SEL, RD_WE, WE, imm_extend_WE
    );

    modport slave (
        output zero, lt, OPC, Func3, Func7,
        input  ALU_OP, SrcA_SEL, SrcB_SEL, fetch, Sel_Reg_In, PC_Control,
               imm_SEL, RD_WE, WE, imm_extend_WE
    );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Outputs are decoded combinationally from the state register and the instruction fields.
module rv32_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst,
    rv32_multicycle_ctrl_if.master        bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t state;
    logic   zero_q;
    logic   lt_q;

    logic is_load;
    logic is_store;
    logic alt_bit;
    logic func7_unused;

    assign is_load      = (bus.OPC == OP_LOAD);
    assign is_store     = (bus.OPC == OP_STORE);
    assign alt_bit      = bus.Func7[5];
    assign func7_unused = ^{bus.Func7[6], bus.Func7[4:0]};

    // Shared Func3 map; I-type passes allow_sub=0 so ADDI never turns into SUB.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                               input logic       allow_sub,
                                               input logic       alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            zero_q <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: state <= EXEC;
                EXEC: begin
                    zero_q <= bus.zero;
                    lt_q   <= bus.lt;
                    state  <= (is_load || is_store) ? MEM : WB;
                end
                MEM:     state <= is_store ? FETCH : WB;
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    logic branch_taken;

    always_comb begin
        branch_taken = 1'b0;
        case (bus.Func3)
            3'b000:  branch_taken = zero_q;
            3'b001:  branch_taken = !zero_q;
            3'b100,
            3'b110:  branch_taken = lt_q;
            3'b101,
            3'b111:  branch_taken = !lt_q;
            default: branch_taken = 1'b0;
        endcase
    end

    logic [3:0] alu_op;
    logic       src_a;
    logic       src_b;
    logic       fetch_s;
    logic [1:0] sel_reg;
    logic [1:0] pc_ctl;
    logic [2:0] imm_sel;
    logic       rd_we;
    logic       mem_we;
    logic       imm_we;

    // Everything is forced to zero while rst is high so an aborted instruction cannot write.
    always_comb begin
        alu_op  = ALU_ADD;
        src_a   = 1'b0;
        src_b   = 1'b0;
        fetch_s = 1'b0;
        sel_reg = 2'b00;
        pc_ctl  = 2'b00;
        imm_sel = 3'b000;
        rd_we   = 1'b0;
        mem_we  = 1'b0;
        imm_we  = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: fetch_s = 1'b1;
                DECODE: begin
                    imm_we = 1'b1;
                    case (bus.OPC)
                        OP_STORE:         imm_sel = 3'b001;
                        OP_BR:            imm_sel = 3'b010;
                        OP_LUI, OP_AUIPC: imm_sel = 3'b011;
                        OP_JAL:           imm_sel = 3'b100;
                        default:          imm_sel = 3'b000;
                    endcase
                end
                EXEC: begin
                    case (bus.OPC)
                        OP_R: alu_op = alu_from_f3(bus.Func3, 1'b1, alt_bit);
                        OP_I: begin
                            alu_op = alu_from_f3(bus.Func3, 1'b0, alt_bit);
                            src_b  = 1'b1;
                        end
                        OP_LOAD, OP_STORE, OP_JALR: src_b = 1'b1;
                        OP_BR: begin
                            case (bus.Func3[2:1])
                                2'b10:   alu_op = ALU_SLT;
                                2'b11:   alu_op = ALU_SLTU;
                                default: alu_op = ALU_SUB;
                            endcase
                        end
                        OP_AUIPC: begin
                            src_a = 1'b1;
                            src_b = 1'b1;
                        end
                        default: alu_op = ALU_ADD;
                    endcase
                end
                MEM: begin
                    if (is_store) begin
                        mem_we = 1'b1;
                        pc_ctl = 2'b01;
                    end
                end
                WB: begin
                    pc_ctl = 2'b01;
                    case (bus.OPC)
                        OP_R, OP_I, OP_AUIPC: rd_we = 1'b1;
                        OP_LOAD: begin
                            rd_we   = 1'b1;
                            sel_reg = 2'b01;
                        end
                        OP_BR: pc_ctl = branch_taken ? 2'b10 : 2'b01;
                        OP_JAL: begin
                            rd_we   = 1'b1;
                            sel_reg = 2'b10;
                            pc_ctl  = 2'b10;
                        end
                        OP_JALR: begin
                            rd_we   = 1'b1;
                            sel_reg = 2'b10;
                            pc_ctl  = 2'b11;
                        end
                        OP_LUI: begin
                            rd_we   = 1'b1;
                            sel_reg = 2'b11;
                        end
                        default: rd_we = 1'b0;
                    endcase
                end
                default: fetch_s = 1'b0;
            endcase
        end
    end

    assign bus.ALU_OP        = alu_op;
    assign bus.SrcA_SEL      = src_a;
    assign bus.SrcB_SEL      = src_b;
    assign bus.fetch         = fetch_s;
    assign bus.Sel_Reg_In    = sel_reg;
    assign bus.PC_Control    = pc_ctl;
    assign bus.imm_SEL       = imm_sel;
    assign bus.RD_WE         = rd_we;
    assign bus.WE            = mem_we;
    assign bus.imm_extend_WE = imm_we;
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: a reference model queues the expected output vector
// for every cycle of an instruction and each cycle pops one and compares it.
module tb_rv32_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_multicycle_ctrl_if bus ();

    rv32_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic       srcb;
        logic       fetch;
        logic [1:0] sel;
        logic [1:0] pc;
        logic [2:0] imm;
        logic       rdwe;
        logic       we;
        logic       immwe;
    } outs_t;

    outs_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic outs_t observe();
        outs_t o;
        o.alu   = bus.ALU_OP;
        o.srca  = bus.SrcA_SEL;
        o.srcb  = bus.SrcB_SEL;
        o.fetch = bus.fetch;
        o.sel   = bus.Sel_Reg_In;
        o.pc    = bus.PC_Control;
        o.imm   = bus.imm_SEL;
        o.rdwe  = bus.RD_WE;
        o.we    = bus.WE;
        o.immwe = bus.imm_extend_WE;
        return o;
    endfunction

    task automatic checkOutput(input string tag, input outs_t got, input outs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    function automatic logic [3:0] alu_table(input logic [2:0] f3);
        logic [3:0] t [8];
        t = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
        return t[f3];
    endfunction

    // Reference model: queue one expected vector per cycle of the instruction.
    task automatic pushModel(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic l);
        outs_t v;
        logic  is_st, is_ld, taken;
        is_st = (opc == 7'b0100011);
        is_ld = (opc == 7'b0000011);

        v = '0; v.fetch = 1'b1; exp_q.push_back(v);

        v = '0; v.immwe = 1'b1;
        if (is_st)                                    v.imm = 3'b001;
        else if (opc == 7'b1100011)                   v.imm = 3'b010;
        else if (opc == 7'b0110111 || opc == 7'b0010111) v.imm = 3'b011;
        else if (opc == 7'b1101111)                   v.imm = 3'b100;
        exp_q.push_back(v);

        v = '0;
        case (opc)
            7'b0110011: v.alu = (f3 == 3'd0 && f7[5]) ? 4'b0001 :
                                (f3 == 3'd5 && f7[5]) ? 4'b0111 : alu_table(f3);
            7'b0010011: begin
                v.alu  = (f3 == 3'd5 && f7[5]) ? 4'b0111 : alu_table(f3);
                v.srcb = 1'b1;
            end
            7'b0000011, 7'b0100011, 7'b1100111: v.srcb = 1'b1;
            7'b1100011: v.alu = !f3[2] ? 4'b0001 : (f3[1] ? 4'b1001 : 4'b1000);
            7'b0010111: begin v.srca = 1'b1; v.srcb = 1'b1; end
            default: v.alu = 4'b0000;
        endcase
        exp_q.push_back(v);

        if (is_st || is_ld) begin
            v = '0;
            if (is_st) begin v.we = 1'b1; v.pc = 2'b01; end
            exp_q.push_back(v);
        end

        if (!is_st) begin
            v = '0; v.pc = 2'b01;
            case (f3)
                3'd0:       taken = z;
                3'd1:       taken = !z;
                3'd4, 3'd6: taken = l;
                3'd5, 3'd7: taken = !l;
                default:    taken = 1'b0;
            endcase
            case (opc)
                7'b0110011, 7'b0010011, 7'b0010111: v.rdwe = 1'b1;
                7'b0000011: begin v.rdwe = 1'b1; v.sel = 2'b01; end
                7'b1100011: v.pc = taken ? 2'b10 : 2'b01;
                7'b1101111: begin v.rdwe = 1'b1; v.sel = 2'b10; v.pc = 2'b10; end
                7'b1100111: begin v.rdwe = 1'b1; v.sel = 2'b10; v.pc = 2'b11; end
                7'b0110111: begin v.rdwe = 1'b1; v.sel = 2'b11; end
                default: v.rdwe = 1'b0;
            endcase
            exp_q.push_back(v);
        end
    endtask

    // Flags carry the requested value only in cycle 2 (EXEC) and the inverse elsewhere.
    task automatic applyStimulus(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input logic l);
        int idx = 0;
        pushModel(opc, f3, f7, z, l);
        bus.OPC = opc; bus.Func3 = f3; bus.Func7 = f7;
        while (exp_q.size() > 0 && idx < 8) begin
            bus.zero = (idx == 2) ? z : !z;
            bus.lt   = (idx == 2) ? l : !l;
            @(negedge clk);
            checkOutput($sformatf("%s.c%0d", name, idx), observe(), exp_q.pop_front());
            @(posedge clk); #1;
            idx++;
        end
    endtask

    task automatic abortInExec();
        outs_t zero_v = '0;
        pushModel(7'b0110011, 3'd0, 7'd0, 1'b0, 1'b0);
        bus.OPC = 7'b0110011; bus.Func3 = 3'd0; bus.Func7 = 7'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort.c%0d", i), observe(), exp_q.pop_front());
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.rst", observe(), zero_v);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        outs_t zero_v = '0;
        logic [6:0] opcs [9];
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rst = 1'b1;
        bus.OPC = 7'b0110011; bus.Func3 = 3'd0; bus.Func7 = 7'd0;
        bus.zero = 1'b0; bus.lt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset.c%0d", i), observe(), zero_v);
            @(posedge clk); #1;
        end
        rst = 1'b0;

        applyStimulus("add",   7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0);
        applyStimulus("sub",   7'b0110011, 3'd0, 7'h20, 1'b0, 1'b0);
        applyStimulus("sra",   7'b0110011, 3'd5, 7'h20, 1'b0, 1'b0);
        applyStimulus("sltu",  7'b0110011, 3'd3, 7'h00, 1'b0, 1'b0);
        applyStimulus("addi",  7'b0010011, 3'd0, 7'h20, 1'b0, 1'b0);
        applyStimulus("srai",  7'b0010011, 3'd5, 7'h20, 1'b0, 1'b0);
        applyStimulus("xori",  7'b0010011, 3'd4, 7'h00, 1'b0, 1'b0);
        applyStimulus("beq_t", 7'b1100011, 3'd0, 7'h00, 1'b1, 1'b0);
        applyStimulus("beq_n", 7'b1100011, 3'd0, 7'h00, 1'b0, 1'b0);
        applyStimulus("bne_t", 7'b1100011, 3'd1, 7'h00, 1'b0, 1'b1);
        applyStimulus("bltu",  7'b1100011, 3'd6, 7'h00, 1'b0, 1'b1);
        applyStimulus("bge_n", 7'b1100011, 3'd5, 7'h00, 1'b1, 1'b1);
        applyStimulus("b010",  7'b1100011, 3'd2, 7'h00, 1'b1, 1'b1);
        applyStimulus("store", 7'b0100011, 3'd2, 7'h00, 1'b0, 1'b0);
        applyStimulus("load",  7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0);
        applyStimulus("jal",   7'b1101111, 3'd0, 7'h00, 1'b0, 1'b0);
        applyStimulus("jalr",  7'b1100111, 3'd0, 7'h00, 1'b0, 1'b0);
        applyStimulus("lui",   7'b0110111, 3'd0, 7'h00, 1'b0, 1'b0);
        applyStimulus("auipc", 7'b0010111, 3'd0, 7'h00, 1'b0, 1'b0);

        abortInExec();
        applyStimulus("illegal", 7'b1111111, 3'd0, 7'h00, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            applyStimulus($sformatf("rnd%0d", i), opcs[$urandom_range(0, 8)],
                          3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
